// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the RV32I hazard controller.
// Holds the forwarding-select encoding, FSM states and the register-match helper.
package core_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN  = 1'b0,
        MISS = 1'b1
    } hz_state_t;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    // x0 is hardwired to zero, so it never creates a dependency.
    function automatic logic reg_match(input logic       we,
                                       input logic [4:0] rd,
                                       input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-register taps and hazard-control outputs.
// The pipeline side uses the master modport, the controller uses slave.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE;
    logic [4:0]       RdM;
    logic             RegWriteM;
    logic             MissM;
    logic [4:0]       RdW;
    logic             RegWriteW;

    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushW;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic [CNT_W-1:0] StallCycles;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
               RdM, RegWriteM, MissM, RdW, RegWriteW,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, StallCycles
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
               RdM, RegWriteM, MissM, RdW, RegWriteW,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, StallCycles
    );

endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// Operand forwarding select for one E-stage source register.
// The younger M-stage result takes priority over the W-stage result.
module fwd_unit
    import core_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rd_m_i,
    input  logic       reg_write_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_w_i,
    output fwd_sel_t   fwd_o
);

    always_comb begin
        fwd_o = FWD_RF;
        if (reg_match(reg_write_m_i, rd_m_i, rs_i)) begin
            fwd_o = FWD_M;
        end else if (reg_match(reg_write_w_i, rd_w_i, rs_i)) begin
            fwd_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage core: load-use stalls, branch
// flushes, data-cache miss freeze, forwarding selects and a stall counter.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int MISS_LATENCY = 4,
    parameter int CNT_W        = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz_if
);

    // The miss cycle itself counts as the first frozen cycle, and the
    // counter reaching zero accounts for the last one.
    localparam logic [3:0] CNT_INIT = 4'(MISS_LATENCY - 2);

    hz_state_t        state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic      frozen;
    logic      lw_stall;
    logic      stall_f;
    fwd_sel_t  fwd_a, fwd_b;

    fwd_unit u_fwd_a (
        .rs_i          (hz_if.Rs1E),
        .rd_m_i        (hz_if.RdM),
        .reg_write_m_i (hz_if.RegWriteM),
        .rd_w_i        (hz_if.RdW),
        .reg_write_w_i (hz_if.RegWriteW),
        .fwd_o         (fwd_a)
    );

    fwd_unit u_fwd_b (
        .rs_i          (hz_if.Rs2E),
        .rd_m_i        (hz_if.RdM),
        .reg_write_m_i (hz_if.RegWriteM),
        .rd_w_i        (hz_if.RdW),
        .reg_write_w_i (hz_if.RegWriteW),
        .fwd_o         (fwd_b)
    );

    assign lw_stall = reg_match(hz_if.ResultSrcE == RESULT_LOAD, hz_if.RdE, hz_if.Rs1D)
                   || reg_match(hz_if.ResultSrcE == RESULT_LOAD, hz_if.RdE, hz_if.Rs2D);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frozen  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (hz_if.MissM) begin
                    frozen  = 1'b1;
                    state_d = MISS;
                    cnt_d   = CNT_INIT;
                end
            end
            MISS: begin
                frozen = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // A taken branch flushes the load-dependent instruction in D, so it
    // suppresses the stall; a freeze overrides both until E is re-presented.
    always_comb begin
        stall_f         = 1'b0;
        hz_if.StallD    = 1'b0;
        hz_if.StallE    = 1'b0;
        hz_if.StallM    = 1'b0;
        hz_if.FlushD    = 1'b0;
        hz_if.FlushE    = 1'b0;
        hz_if.FlushW    = 1'b0;
        hz_if.ForwardAE = FWD_RF;
        hz_if.ForwardBE = FWD_RF;
        if (!rst_n) begin
            hz_if.FlushD = 1'b1;
            hz_if.FlushE = 1'b1;
        end else begin
            hz_if.ForwardAE = fwd_a;
            hz_if.ForwardBE = fwd_b;
            if (frozen) begin
                stall_f      = 1'b1;
                hz_if.StallD = 1'b1;
                hz_if.StallE = 1'b1;
                hz_if.StallM = 1'b1;
                hz_if.FlushW = 1'b1;
            end else begin
                stall_f      = lw_stall && !hz_if.PCSrcE;
                hz_if.StallD = lw_stall && !hz_if.PCSrcE;
                hz_if.FlushD = hz_if.PCSrcE;
                hz_if.FlushE = lw_stall || hz_if.PCSrcE;
            end
        end
    end

    assign hz_if.StallF = stall_f;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_f && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign hz_if.StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_hazard_ctrl;
    import core_pkg::*;

    localparam int LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, RegWriteM, MissM, RegWriteW;

    hazard_ctrl_if #(.CNT_W(16)) hz16 ();
    hazard_ctrl_if #(.CNT_W(4))  hz4 ();

    assign hz16.Rs1D = Rs1D;             assign hz4.Rs1D = Rs1D;
    assign hz16.Rs2D = Rs2D;             assign hz4.Rs2D = Rs2D;
    assign hz16.Rs1E = Rs1E;             assign hz4.Rs1E = Rs1E;
    assign hz16.Rs2E = Rs2E;             assign hz4.Rs2E = Rs2E;
    assign hz16.RdE = RdE;               assign hz4.RdE = RdE;
    assign hz16.ResultSrcE = ResultSrcE; assign hz4.ResultSrcE = ResultSrcE;
    assign hz16.PCSrcE = PCSrcE;         assign hz4.PCSrcE = PCSrcE;
    assign hz16.RdM = RdM;               assign hz4.RdM = RdM;
    assign hz16.RegWriteM = RegWriteM;   assign hz4.RegWriteM = RegWriteM;
    assign hz16.MissM = MissM;           assign hz4.MissM = MissM;
    assign hz16.RdW = RdW;               assign hz4.RdW = RdW;
    assign hz16.RegWriteW = RegWriteW;   assign hz4.RegWriteW = RegWriteW;

    hazard_ctrl #(.MISS_LATENCY(LAT), .CNT_W(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .hz_if (hz16.slave)
    );

    hazard_ctrl #(.MISS_LATENCY(LAT), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .hz_if (hz4.slave)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    // Model state: remaining frozen cycles after the current one, and the
    // ideal stall counts for each counter width.
    int freeze_left;
    int m_cnt16, m_cnt4;
    logic e_stallf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; MissM = 0; RegWriteW = 0;
    endtask

    // Sample on the falling edge and compare every output of both DUTs.
    task automatic step_check();
        logic lw, frozen;
        logic [10:0] exp_v, act16, act4;
        @(negedge clk);
        if (!rst_n) begin
            freeze_left = 0; m_cnt16 = 0; m_cnt4 = 0;
        end
        lw = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        frozen = (freeze_left > 0) || MissM;
        if (!rst_n) begin
            exp_v = {7'b0000110, 4'b0000};
        end else if (frozen) begin
            exp_v = {7'b1111001, m_fwd(Rs1E), m_fwd(Rs2E)};
        end else begin
            exp_v = {lw && !PCSrcE, lw && !PCSrcE, 2'b00, PCSrcE, lw || PCSrcE, 1'b0,
                     m_fwd(Rs1E), m_fwd(Rs2E)};
        end
        e_stallf = exp_v[10];
        act16 = {hz16.StallF, hz16.StallD, hz16.StallE, hz16.StallM, hz16.FlushD,
                 hz16.FlushE, hz16.FlushW, hz16.ForwardAE, hz16.ForwardBE};
        act4  = {hz4.StallF, hz4.StallD, hz4.StallE, hz4.StallM, hz4.FlushD,
                 hz4.FlushE, hz4.FlushW, hz4.ForwardAE, hz4.ForwardBE};
        chk("ctl16", 32'(act16), 32'(exp_v));
        chk("ctl4", 32'(act4), 32'(exp_v));
        chk("cnt16", 32'(hz16.StallCycles), 32'(m_cnt16));
        chk("cnt4", 32'(hz4.StallCycles), 32'(m_cnt4));
    endtask

    task automatic step_adv();
        @(posedge clk);
        if (!rst_n) begin
            freeze_left = 0; m_cnt16 = 0; m_cnt4 = 0;
        end else begin
            if (e_stallf) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (freeze_left > 0) freeze_left--;
            else if (MissM) freeze_left = LAT - 1;
        end
        #1;
    endtask

    task automatic tick();
        step_check();
        step_adv();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        RegWriteM = 1; RdM = 3; Rs1E = 3; PCSrcE = 1;
        step_check();
        chk("rst_flushD", 32'(hz16.FlushD), 32'd1);
        chk("rst_flushE", 32'(hz16.FlushE), 32'd1);
        chk("rst_stallF", 32'(hz16.StallF), 32'd0);
        chk("rst_fwdA", 32'(hz16.ForwardAE), 32'd0);
        step_adv();
        idle();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        freeze_left = 0; m_cnt16 = 0; m_cnt4 = 0; e_stallf = 0;
        do_reset();
        chk("rst_cnt", 32'(hz16.StallCycles), 32'd0);

        // Load-use stall for one cycle.
        idle(); ResultSrcE = 2'b01; RdE = 5; Rs1D = 5;
        step_check();
        chk("lu_stallF", 32'(hz16.StallF), 32'd1);
        chk("lu_stallD", 32'(hz16.StallD), 32'd1);
        chk("lu_flushE", 32'(hz16.FlushE), 32'd1);
        chk("lu_flushD", 32'(hz16.FlushD), 32'd0);
        step_adv();
        idle();
        step_check();
        chk("lu_cnt", 32'(hz16.StallCycles), 32'd1);
        chk("lu_release", 32'(hz16.StallF), 32'd0);
        step_adv();

        // Forwarding priority.
        idle(); RegWriteM = 1; RegWriteW = 1; RdM = 7; RdW = 7; Rs1E = 7; Rs2E = 0;
        step_check();
        chk("fwd_m", 32'(hz16.ForwardAE), 32'd2);
        chk("fwd_b0", 32'(hz16.ForwardBE), 32'd0);
        step_adv();
        RegWriteM = 0;
        step_check();
        chk("fwd_w", 32'(hz16.ForwardAE), 32'd1);
        step_adv();

        // Branch beats load-use.
        idle(); ResultSrcE = 2'b01; RdE = 9; Rs2D = 9; PCSrcE = 1;
        step_check();
        chk("br_flushD", 32'(hz16.FlushD), 32'd1);
        chk("br_flushE", 32'(hz16.FlushE), 32'd1);
        chk("br_stallF", 32'(hz16.StallF), 32'd0);
        chk("br_stallD", 32'(hz16.StallD), 32'd0);
        step_adv();

        // Single miss freezes exactly LAT cycles.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            idle(); MissM = (i == 0);
            step_check();
            chk("miss_stallF", 32'(hz16.StallF), 32'(i < 4));
            chk("miss_stallM", 32'(hz16.StallM), 32'(i < 4));
            chk("miss_flushW", 32'(hz16.FlushW), 32'(i < 4));
            step_adv();
        end
        chk("miss_cnt", 32'(hz16.StallCycles), 32'd4);

        // Miss with a taken branch: branch waits for the freeze to end.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle(); MissM = (i == 0); PCSrcE = 1;
            step_check();
            chk("mb_flushD", 32'(hz16.FlushD), 32'(i == 4));
            chk("mb_flushE", 32'(hz16.FlushE), 32'(i == 4));
            chk("mb_stallF", 32'(hz16.StallF), 32'(i < 4));
            step_adv();
        end

        // Reset during the second frozen cycle aborts the freeze.
        do_reset();
        idle(); MissM = 1;
        tick();
        idle(); rst_n = 1'b0;
        step_check();
        chk("rm_flushD", 32'(hz16.FlushD), 32'd1);
        chk("rm_flushE", 32'(hz16.FlushE), 32'd1);
        chk("rm_stallF", 32'(hz16.StallF), 32'd0);
        chk("rm_cnt", 32'(hz16.StallCycles), 32'd0);
        step_adv();
        rst_n = 1'b1;
        step_check();
        chk("rm_after", 32'(hz16.StallF), 32'd0);
        step_adv();

        // Back-to-back misses for 20 cycles saturate the narrow counter.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            idle(); MissM = 1;
            tick();
        end
        idle();
        step_check();
        chk("sat_cnt4", 32'(hz4.StallCycles), 32'd15);
        chk("sat_cnt16", 32'(hz16.StallCycles), 32'd20);
        step_adv();

        // Randomized traffic on a small register set to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            Rs1D       = 5'($urandom_range(0, 3));
            Rs2D       = 5'($urandom_range(0, 3));
            Rs1E       = 5'($urandom_range(0, 3));
            Rs2E       = 5'($urandom_range(0, 3));
            RdE        = 5'($urandom_range(0, 3));
            RdM        = 5'($urandom_range(0, 3));
            RdW        = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE     = ($urandom_range(0, 4) == 0);
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            MissM      = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
